// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for div/divu
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 stall_req,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic [2*WIDTH+1:0]   hilo_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    // {rem[WIDTH:0], quo[WIDTH-1:0]}
    logic [2*WIDTH:0]   work;
    logic [WIDTH-1:0]   dvsr_mag;
    logic               q_neg;
    logic               r_neg;
    logic [5:0]         cnt;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   rem_r;

    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH:0]   work_step;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last_iter;

    // One restoring step plus operand magnitudes and final sign fix-up.
    always_comb begin
        shifted   = {work[2*WIDTH-1:0], 1'b0};
        diff      = shifted[2*WIDTH:WIDTH] - {1'b0, dvsr_mag};
        work_step = shifted;
        if (shifted[2*WIDTH:WIDTH] >= {1'b0, dvsr_mag}) begin
            work_step[2*WIDTH:WIDTH] = diff;
            work_step[0]             = 1'b1;
        end
        a_mag   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        quo_fix = q_neg ? -work_step[WIDTH-1:0] : work_step[WIDTH-1:0];
        rem_fix = r_neg ? -work_step[2*WIDTH-1:WIDTH] : work_step[2*WIDTH-1:WIDTH];
        last_iter = (cnt == 6'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; flush overrides everything.
    always_comb begin
        state_nx  = state;
        stall_req = start && (state != S_DONE) && !flush;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE) && !flush;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (flush) begin
            state_nx = S_IDLE;
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= '0;
            dvsr_mag <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            cnt      <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
        end else if (flush) begin
            work     <= '0;
            dvsr_mag <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        work     <= {{(WIDTH+1){1'b0}}, a_mag};
                        dvsr_mag <= b_mag;
                        q_neg    <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg    <= signed_op && dividend[WIDTH-1];
                        // Divide by zero skips iteration; result is known now.
                        if (divisor == '0) begin
                            quo_r <= '1;
                            rem_r <= dividend;
                        end
                    end
                end
                S_RUN: begin
                    work <= work_step;
                    cnt  <= cnt + 6'd1;
                    if (last_iter) begin
                        quo_r <= quo_fix;
                        rem_r <= rem_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = quo_r;
    assign remainder   = rem_r;
    assign hilo_result = done ? {1'b1, 1'b1, rem_r, quo_r} : '0;

endmodule
